// File: rtl/mayur_wallace_mac.sv
// mayur_wallace_mac: saturating multiply-accumulate stage built around a
// 3x3 Wallace-tree multiplier. Operand pairs arrive over a valid/ready
// handshake. Each 6-bit product is registered and then added into an
// ACC_W-bit saturating accumulator. After N_TERMS products, the frame sum is
// held on an output handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous frame abort; has priority over every other event
//   in_valid   operand pair valid
//   in_ready   stage can accept an operand pair
//   A, B       3-bit unsigned operands
//   out_valid  frame result valid
//   out_ready  downstream accepts the result
//   acc_out    frame sum (unsigned, saturating)
//   overflow   frame saturated; meaningful while out_valid=1
module mayur_wallace_mac #(
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  localparam logic [7:0]       N_CNT   = 8'(N_TERMS);
  localparam logic [7:0]       N_LAST  = 8'(N_TERMS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // Wallace-tree 3x3 multiplier. p_ij = A[i] & B[j], weight i+j.
  logic p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic s1, c1, s2, c2, s3, c3;
  logic r2, k2, r3, k3, r4, r5;
  logic [5:0] prod;

  assign p00 = A[0] & B[0];
  assign p01 = A[0] & B[1];
  assign p02 = A[0] & B[2];
  assign p10 = A[1] & B[0];
  assign p11 = A[1] & B[1];
  assign p12 = A[1] & B[2];
  assign p20 = A[2] & B[0];
  assign p21 = A[2] & B[1];
  assign p22 = A[2] & B[2];

  // Reduction layer: HA on weight 1, FA on weight 2, HA on weight 3.
  assign s1 = p01 ^ p10;
  assign c1 = p01 & p10;
  assign s2 = p02 ^ p11 ^ p20;
  assign c2 = (p02 & p11) | (p20 & (p02 ^ p11));
  assign s3 = p12 ^ p21;
  assign c3 = p12 & p21;

  // Final carry-propagate adder over the two remaining rows.
  assign r2 = s2 ^ c1;
  assign k2 = s2 & c1;
  assign r3 = s3 ^ c2 ^ k2;
  assign k3 = (s3 & c2) | (k2 & (s3 ^ c2));
  assign r4 = p22 ^ c3 ^ k3;
  assign r5 = (p22 & c3) | (k3 & (p22 ^ c3));

  assign prod = {r5, r4, r3, r2, s1, p00};

  // Accumulator state.
  logic [0:0]       state_q, state_d;
  logic             init_q;
  logic [5:0]       prod_q, prod_d;
  logic             p_valid_q, p_valid_d;
  logic [7:0]       issue_cnt_q, issue_cnt_d;
  logic [7:0]       term_cnt_q, term_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [ACC_W:0]   sum;

  // init_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = init_q && (state_q == ST_ACCUM) && (issue_cnt_q != N_CNT);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

  assign sum = {1'b0, acc_q} + {{(ACC_W - 5){1'b0}}, prod_q};

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    p_valid_d   = 1'b0;
    issue_cnt_d = issue_cnt_q;
    term_cnt_d  = term_cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (clear) begin
      state_d     = ST_ACCUM;
      issue_cnt_d = '0;
      term_cnt_d  = '0;
      acc_d       = '0;
      ovf_d       = 1'b0;
    end else if (state_q == ST_DONE) begin
      if (out_ready) begin
        state_d     = ST_ACCUM;
        issue_cnt_d = '0;
        term_cnt_d  = '0;
        acc_d       = '0;
        ovf_d       = 1'b0;
      end
    end else begin
      // Product only captured on accept so unaccepted operands never leak in.
      if (accept) begin
        prod_d      = prod;
        p_valid_d   = 1'b1;
        issue_cnt_d = issue_cnt_q + 8'd1;
      end
      if (p_valid_q) begin
        if (sum[ACC_W]) begin
          acc_d = ACC_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        term_cnt_d = term_cnt_q + 8'd1;
        if (term_cnt_q == N_LAST) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      init_q      <= 1'b0;
      prod_q      <= '0;
      p_valid_q   <= 1'b0;
      issue_cnt_q <= '0;
      term_cnt_q  <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      prod_q      <= prod_d;
      p_valid_q   <= p_valid_d;
      issue_cnt_q <= issue_cnt_d;
      term_cnt_q  <= term_cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mayur_wallace_mac.sv
// Self-checking bench for mayur_wallace_mac. Three instances cover the
// default configuration, N_TERMS=1 and ACC_W=8. The reference model is a plain
// frame sum clamped to 2^ACC_W-1, with the timing derived from the accept
// cycle.
module tb_mayur_wallace_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv, orr, clr, ir, ov, ovf;
  logic [2:0] a_s [3];
  logic [2:0] b_s [3];
  logic [11:0] acc0, acc1;
  logic [7:0]  acc2;

  int n_cmp = 0;
  int n_bad = 0;
  int pa[$];
  int pb[$];

  always #5 clk = ~clk;

  mayur_wallace_mac #(.ACC_W(12), .N_TERMS(8)) u_mac_def (
    .clk(clk), .rst(rst), .clear(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a_s[0]), .B(b_s[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .acc_out(acc0), .overflow(ovf[0])
  );

  mayur_wallace_mac #(.ACC_W(12), .N_TERMS(1)) u_mac_one (
    .clk(clk), .rst(rst), .clear(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a_s[1]), .B(b_s[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .acc_out(acc1), .overflow(ovf[1])
  );

  mayur_wallace_mac #(.ACC_W(8), .N_TERMS(8)) u_mac_sat (
    .clk(clk), .rst(rst), .clear(clr[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(a_s[2]), .B(b_s[2]), .out_valid(ov[2]), .out_ready(orr[2]),
    .acc_out(acc2), .overflow(ovf[2])
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint get_acc(input int k);
    case (k)
      0:       return longint'(acc0);
      1:       return longint'(acc1);
      default: return longint'(acc2);
    endcase
  endfunction

  task automatic fill(input int n, input int a, input int b);
    pa.delete();
    pb.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back(a);
      pb.push_back(b);
    end
  endtask

  // Runs one frame on instance k from a clean ACCUM state, starting just after
  // a rising edge. Ends just after the first edge following the idle cycle.
  task automatic run_frame(input int k, input int n, input int accw, input int bubble,
                           input int bp, input string tag);
    int     acc_n, last, cyc, hold;
    longint sum, maxv, exp_acc;
    bit     done, exp_rdy, exp_ov;
    maxv  = (longint'(1) << accw) - 1;
    acc_n = 0;
    last  = -100;
    cyc   = 0;
    hold  = 0;
    sum   = 0;
    done  = 1'b0;
    while (!done && cyc < 400) begin
      exp_rdy = (acc_n < n);
      exp_ov  = (acc_n == n) && (cyc >= last + 2);
      if (exp_rdy) iv[k] = ($urandom_range(99) >= 32'(bubble));
      else         iv[k] = 1'($urandom);
      if (exp_rdy && iv[k]) begin
        a_s[k] = 3'(pa[acc_n]);
        b_s[k] = 3'(pb[acc_n]);
      end else begin
        a_s[k] = 3'($urandom);
        b_s[k] = 3'($urandom);
      end
      orr[k] = exp_ov ? (hold >= bp) : 1'($urandom);
      @(negedge clk);
      check_eq({tag, "_in_ready"}, longint'(ir[k]), longint'(exp_rdy));
      check_eq({tag, "_out_valid"}, longint'(ov[k]), longint'(exp_ov));
      if (exp_ov) begin
        exp_acc = (sum > maxv) ? maxv : sum;
        check_eq({tag, "_acc_out"}, get_acc(k), exp_acc);
        check_eq({tag, "_overflow"}, longint'(ovf[k]), longint'(sum > maxv));
        if (orr[k]) done = 1'b1;
        else        hold++;
      end
      if (iv[k] && exp_rdy) begin
        sum  += longint'(pa[acc_n] * pb[acc_n]);
        last  = cyc;
        acc_n++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_completed"}, longint'(done), 1);
    iv[k]  = 1'b0;
    orr[k] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_post_out_valid"}, longint'(ov[k]), 0);
    check_eq({tag, "_post_in_ready"}, longint'(ir[k]), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    iv  = '0;
    orr = '0;
    clr = '0;
    for (int k = 0; k < 3; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end
    #12;
    check_eq("rst_in_ready", longint'(ir[0]), 0);
    check_eq("rst_out_valid", longint'(ov[0]), 0);
    check_eq("rst_acc_out", longint'(acc0), 0);
    check_eq("rst_overflow", longint'(ovf[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-rate frame of 7x7.
    fill(8, 7, 7);
    run_frame(0, 8, 12, 0, 0, "t1_7x7");

    // Every product with N_TERMS=1.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        fill(1, a, b);
        run_frame(1, 1, 12, 0, 0, "t2_exh");
      end
    end

    // Saturation at ACC_W=8, then a clean frame clears the sticky flag.
    fill(8, 7, 7);
    run_frame(2, 8, 8, 0, 0, "t3_sat");
    fill(8, 1, 1);
    run_frame(2, 8, 8, 0, 0, "t3_next");

    // Random operands, bubbles and output backpressure.
    for (int f = 0; f < 4; f++) begin
      pa.delete();
      pb.delete();
      for (int i = 0; i < 8; i++) begin
        pa.push_back(int'($urandom_range(7)));
        pb.push_back(int'($urandom_range(7)));
      end
      run_frame(0, 8, 12, 40, 5, "t4_bp");
    end

    // Abort after 3 accepted pairs; clear wins over a concurrent accept.
    iv[0]  = 1'b1;
    a_s[0] = 3'd3;
    b_s[0] = 3'd3;
    repeat (3) begin
      @(negedge clk);
      check_eq("t5_pre_ready", longint'(ir[0]), 1);
      @(posedge clk);
      #1;
    end
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    iv[0]  = 1'b0;
    @(negedge clk);
    check_eq("t5_clr_acc", longint'(acc0), 0);
    check_eq("t5_clr_ready", longint'(ir[0]), 1);
    @(posedge clk);
    #1;
    check_eq("t5_clr_acc_dropped", longint'(acc0), 0);
    check_eq("t5_clr_out_valid", longint'(ov[0]), 0);
    fill(8, 2, 3);
    run_frame(0, 8, 12, 0, 0, "t5_after");

    // Clear while the result is held; clear beats the output handshake.
    iv[0]  = 1'b1;
    a_s[0] = 3'd1;
    b_s[0] = 3'd1;
    orr[0] = 1'b0;
    w = 0;
    while (!ov[0] && w < 30) begin
      @(posedge clk);
      #1;
      w++;
    end
    iv[0] = 1'b0;
    check_eq("t6_done_seen", longint'(ov[0]), 1);
    check_eq("t6_done_acc", longint'(acc0), 8);
    clr[0] = 1'b1;
    orr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    orr[0] = 1'b0;
    check_eq("t6_clr_out_valid", longint'(ov[0]), 0);
    check_eq("t6_clr_acc", longint'(acc0), 0);
    check_eq("t6_clr_ready", longint'(ir[0]), 1);

    // Async reset between edges with the last product still in flight.
    iv[0]  = 1'b1;
    a_s[0] = 3'd1;
    b_s[0] = 3'd1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    check_eq("t7_pre_acc", longint'(acc0), 7);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t7_rst_acc", longint'(acc0), 0);
    check_eq("t7_rst_out_valid", longint'(ov[0]), 0);
    check_eq("t7_rst_overflow", longint'(ovf[0]), 0);
    check_eq("t7_rst_ready", longint'(ir[0]), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t7_post_out_valid", longint'(ov[0]), 0);
    check_eq("t7_post_ready", longint'(ir[0]), 1);
    fill(8, 1, 2);
    run_frame(0, 8, 12, 0, 0, "t7_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
